id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised decode stage with its own ID/EX pipeline register. Reads a NUM_REGS x DATA_W
//  register file with WB write-through bypass, decodes via the team decoder, detects load-use
//  hazards (stall + bubble), and honours EX flush and downstream hold. Sits between IF and EX.
// PARAMETERS
//  DATA_W    32  register/data width
//  NUM_REGS  32  architectural registers (power of 2); reg 0 reads as zero, writes ignored
//  ADDR_W    5   log2(NUM_REGS); register index fields are instr[25:21]/[20:16]/[15:11] low ADDR_W bits
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       synchronous active-high reset
//  id_instr     in   32      instruction from IF/ID
//  id_valid     in   1       id_instr is a real instruction
//  wb_wen       in   1       WB register write enable
//  wb_waddr     in   ADDR_W  WB write index
//  wb_wdata     in   DATA_W  WB write data
//  ex_flush     in   1       EX redirect (taken jump/branch): kill ID and ID/EX contents
//  ex_hold      in   1       downstream stall: freeze ID/EX register
//  stall_if     out  1       hold PC and IF/ID this cycle (combinational)
//  ex_valid     out  1       ID/EX holds a live instruction
//  ex_instr     out  32      registered instruction
//  ex_rs_data   out  DATA_W  registered rs operand
//  ex_rt_data   out  DATA_W  registered rt operand
//  ex_dest      out  ADDR_W  registered destination index
//  ex_ctrl      out  21      registered control; bit20..0 = writeRd,ldic,isSignEx,immed,alu_ctrl3..0,
//                            isJump,isJR,rs_read,rt_read,mem_ren,mem_wen,lw,link,reg_wen,str_ccnt,str_icnt,stp_cnt,inc_instr
// BEHAVIOUR
//  - Reset: all registers in file = 0; ex_valid=0, ex_instr=0, ex_rs/rt_data=0, ex_dest=0, ex_ctrl=0.
//  - Read: combinational from file; if wb_wen && wb_waddr==src && src!=0, wb_wdata is forwarded
//    (write-through). Source index 0 always yields 0.
//  - Write: on clk edge when wb_wen && wb_waddr!=0 (also while stalled/held/flushed).
//  - Dest: link -> NUM_REGS-1; else writeRd -> instr[15:11]; else instr[20:16].
//  - Load-use hazard (luh) = id_valid && ex_valid && ex_ctrl.lw && ex_dest!=0 &&
//    ((rs_read && rs==ex_dest) || (rt_read && rt==ex_dest)).
//  - stall_if = !ex_flush && (ex_hold || luh).
//  - ID/EX update, priority order each edge:
//    1 rst  -> reset values.
//    2 ex_flush -> ex_valid=0, ex_ctrl=0 (bubble); ID instruction discarded (IF refetches).
//    3 ex_hold  -> all ID/EX fields keep value.
//    4 luh      -> bubble (ex_valid=0, ex_ctrl=0); ID instruction re-presented next cycle.
//    5 else     -> capture decode; ex_valid=id_valid; ex_ctrl=id_valid ? decode : 0.
//  - Latency: 1 cycle ID->EX; load-use costs exactly 1 bubble (lw then leaves EX, no rematch).
//  - Invalid slot never asserts mem_wen/reg_wen/inc_instr at EX.
//  - Reset mid-stall: stall_if drops the cycle after rst since ex_valid=0.
// TESTING
//  1 Reset: rst=1 two cycles -> all ex_* = 0, reads of r1..r31 return 0.
//  2 Bypass: wb_wen=1 waddr=5 wdata=0xDEADBEEF, same cycle id rs=5 -> ex_rs_data=0xDEADBEEF next edge;
//    waddr=0 wdata=0x1234 -> r0 still reads 0.
//  3 Load-use: lw r7 then add using rs=r7 -> cycle2 stall_if=1, ex_valid=0; cycle3 add enters EX,
//    stall_if=0; same with rs=r0 dest -> no stall.
//  4 Flush: ex_flush=1 with ex_hold=1 and luh active -> stall_if=0, next ex_valid=0, ex_ctrl=0.
//  5 Hold: ex_hold=1 for 3 cycles -> ex_* unchanged, stall_if=1; WB write to r9 still lands.
//  6 Link dest: jal-type (link=1) -> ex_dest=31; writeRd=1 rd=12 -> ex_dest=12; else ex_dest=rt.

Source files
------------

// File: rtl/id_stage_if.sv
// Purpose : IF/ID, WB and ID/EX signal bundle for the decode stage (slave = decode stage side).
// Latency : n/a (wires only).
// Backpressure: stall_if from the stage back to IF; ex_hold/ex_flush into the stage from EX.
// Ports   : id_instr/id_valid (IF->ID), wb_wen/wb_waddr/wb_wdata (WB write port),
//           ex_flush/ex_hold (EX control), stall_if, ex_valid/ex_instr/ex_rs_data/ex_rt_data/ex_dest/ex_ctrl.
interface id_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [31:0]       id_instr;
    logic              id_valid;
    logic              wb_wen;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              ex_flush;
    logic              ex_hold;
    logic              stall_if;
    logic              ex_valid;
    logic [31:0]       ex_instr;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [ADDR_W-1:0] ex_dest;
    logic [20:0]       ex_ctrl;

    // Driven by the surrounding pipeline (IF, WB, EX).
    modport master (
        output id_instr, id_valid, wb_wen, wb_waddr, wb_wdata, ex_flush, ex_hold,
        input  stall_if, ex_valid, ex_instr, ex_rs_data, ex_rt_data, ex_dest, ex_ctrl
    );

    // The decode stage itself.
    modport slave (
        input  id_instr, id_valid, wb_wen, wb_waddr, wb_wdata, ex_flush, ex_hold,
        output stall_if, ex_valid, ex_instr, ex_rs_data, ex_rt_data, ex_dest, ex_ctrl
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Purpose : decode stage: register file with WB write-through, instruction decode, load-use
//           hazard detection, and the ID/EX pipeline register.
// Latency : 1 cycle ID->EX; a load-use hazard inserts exactly one bubble.
// Backpressure: stall_if holds IF on ex_hold or load-use (never during ex_flush); ex_hold freezes ID/EX.
// Ports   : clk, rst (sync, active high), bus (id_stage_if.slave, see interface file).
module id_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic     clk,
    input  logic     rst,
    id_stage_if.slave bus
);

    typedef struct packed {
        logic       write_rd;
        logic       ldic;
        logic       is_sign_ex;
        logic       immed;
        logic [3:0] alu_ctrl;
        logic       is_jump;
        logic       is_jr;
        logic       rs_read;
        logic       rt_read;
        logic       mem_ren;
        logic       mem_wen;
        logic       lw;
        logic       link;
        logic       reg_wen;
        logic       str_ccnt;
        logic       str_icnt;
        logic       stp_cnt;
        logic       inc_instr;
    } ctrl_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [DATA_W-1:0] rf [NUM_REGS];

    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] rs_idx;
    logic [ADDR_W-1:0] rt_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    ctrl_t             dec;
    logic              luh;

    logic              ex_valid_q;
    logic [31:0]       ex_instr_q;
    logic [DATA_W-1:0] ex_rs_q;
    logic [DATA_W-1:0] ex_rt_q;
    logic [ADDR_W-1:0] ex_dest_q;
    ctrl_t             ex_ctrl_q;

    assign instr  = bus.id_instr;
    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rs_idx = instr[21 +: ADDR_W];
    assign rt_idx = instr[16 +: ADDR_W];
    assign rd_idx = instr[11 +: ADDR_W];

    // Shift-amount field is not used by any supported instruction.
    logic unused_shamt;
    assign unused_shamt = ^instr[10:6];

    // Register file reads; a same-cycle WB write to the source is forwarded.
    always_comb begin
        rs_data = '0;
        if (rs_idx != '0) begin
            if (bus.wb_wen && bus.wb_waddr == rs_idx) rs_data = bus.wb_wdata;
            else                                      rs_data = rf[rs_idx];
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt_idx != '0) begin
            if (bus.wb_wen && bus.wb_waddr == rt_idx) rt_data = bus.wb_wdata;
            else                                      rt_data = rf[rt_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (bus.wb_wen && bus.wb_waddr != '0) begin
            rf[bus.wb_waddr] <= bus.wb_wdata;
        end
    end

    // Instruction decode; unrecognised encodings decode to all-zero control.
    always_comb begin
        dec = '0;
        case (opcode)
            6'h00: begin
                dec.write_rd  = 1'b1;
                dec.rs_read   = 1'b1;
                dec.rt_read   = 1'b1;
                dec.reg_wen   = 1'b1;
                dec.inc_instr = 1'b1;
                case (funct)
                    6'h20: dec.alu_ctrl = ALU_ADD;
                    6'h22: dec.alu_ctrl = ALU_SUB;
                    6'h24: dec.alu_ctrl = ALU_AND;
                    6'h25: dec.alu_ctrl = ALU_OR;
                    6'h2A: dec.alu_ctrl = ALU_SLT;
                    6'h08: begin
                        dec           = '0;
                        dec.is_jr     = 1'b1;
                        dec.rs_read   = 1'b1;
                        dec.inc_instr = 1'b1;
                    end
                    default: dec = '0;
                endcase
            end
            6'h08: begin // addi
                dec.is_sign_ex = 1'b1; dec.immed = 1'b1; dec.alu_ctrl = ALU_ADD;
                dec.rs_read = 1'b1; dec.reg_wen = 1'b1; dec.inc_instr = 1'b1;
            end
            6'h0C: begin // andi
                dec.immed = 1'b1; dec.alu_ctrl = ALU_AND;
                dec.rs_read = 1'b1; dec.reg_wen = 1'b1; dec.inc_instr = 1'b1;
            end
            6'h0D: begin // ori
                dec.immed = 1'b1; dec.alu_ctrl = ALU_OR;
                dec.rs_read = 1'b1; dec.reg_wen = 1'b1; dec.inc_instr = 1'b1;
            end
            6'h0F: begin // lui
                dec.ldic = 1'b1; dec.immed = 1'b1; dec.reg_wen = 1'b1; dec.inc_instr = 1'b1;
            end
            6'h23: begin // lw
                dec.is_sign_ex = 1'b1; dec.immed = 1'b1; dec.alu_ctrl = ALU_ADD;
                dec.rs_read = 1'b1; dec.mem_ren = 1'b1; dec.lw = 1'b1;
                dec.reg_wen = 1'b1; dec.inc_instr = 1'b1;
            end
            6'h2B: begin // sw
                dec.is_sign_ex = 1'b1; dec.immed = 1'b1; dec.alu_ctrl = ALU_ADD;
                dec.rs_read = 1'b1; dec.rt_read = 1'b1; dec.mem_wen = 1'b1; dec.inc_instr = 1'b1;
            end
            6'h04: begin // beq
                dec.is_sign_ex = 1'b1; dec.alu_ctrl = ALU_SUB;
                dec.rs_read = 1'b1; dec.rt_read = 1'b1; dec.inc_instr = 1'b1;
            end
            6'h02: begin // j
                dec.is_jump = 1'b1; dec.inc_instr = 1'b1;
            end
            6'h03: begin // jal
                dec.is_jump = 1'b1; dec.link = 1'b1; dec.reg_wen = 1'b1; dec.inc_instr = 1'b1;
            end
            6'h30: begin dec.str_ccnt = 1'b1; dec.inc_instr = 1'b1; end
            6'h31: begin dec.str_icnt = 1'b1; dec.inc_instr = 1'b1; end
            6'h32: begin dec.stp_cnt  = 1'b1; dec.inc_instr = 1'b1; end
            default: dec = '0;
        endcase
    end

    always_comb begin
        if (dec.link)          dest = ADDR_W'(NUM_REGS - 1);
        else if (dec.write_rd) dest = rd_idx;
        else                   dest = rt_idx;
    end

    // A load in EX whose result is needed now: its data only exists after MEM.
    assign luh = bus.id_valid && ex_valid_q && ex_ctrl_q.lw && (ex_dest_q != '0) &&
                 ((dec.rs_read && rs_idx == ex_dest_q) || (dec.rt_read && rt_idx == ex_dest_q));

    // A flush redirects IF, so holding it would fight the redirect.
    assign bus.stall_if = !bus.ex_flush && (bus.ex_hold || luh);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_instr_q <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_dest_q  <= '0;
            ex_ctrl_q  <= '0;
        end else if (bus.ex_flush) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
        end else if (bus.ex_hold) begin
            ex_valid_q <= ex_valid_q;
        end else if (luh) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= bus.id_valid;
            ex_instr_q <= instr;
            ex_rs_q    <= rs_data;
            ex_rt_q    <= rt_data;
            ex_dest_q  <= dest;
            ex_ctrl_q  <= bus.id_valid ? dec : ctrl_t'('0);
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_instr   = ex_instr_q;
    assign bus.ex_rs_data = ex_rs_q;
    assign bus.ex_rt_data = ex_rt_q;
    assign bus.ex_dest    = ex_dest_q;
    assign bus.ex_ctrl    = ex_ctrl_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Purpose : self-checking bench for id_stage_pipe: directed scenarios plus randomized traffic
//           compared every cycle against a behavioural model of the decode stage.
// Latency : model expects 1 cycle ID->EX and one bubble per load-use.
// Backpressure: bench re-presents the ID instruction whenever stall_if is high.
module tb_id_stage_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    id_stage_pipe #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Control bit positions, by name.
    localparam int B_WRD = 20, B_LDIC = 19, B_SEX = 18, B_IMM = 17, B_ALU = 13;
    localparam int B_J = 12, B_JR = 11, B_RS = 10, B_RT = 9, B_MR = 8, B_MW = 7;
    localparam int B_LW = 6, B_LINK = 5, B_RW = 4, B_SC = 3, B_SI = 2, B_SP = 1, B_INC = 0;

    // Behavioural state: architectural registers and the EX slot contents.
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_rs;
    logic [31:0] m_rt;
    logic [4:0]  m_dest;
    logic [20:0] m_ctrl;
    logic        last_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [20:0] bit_of(input int b);
        logic [20:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [20:0] alu(input int code);
        return 21'(code) << B_ALU;
    endfunction

    // Control word per instruction, listed as the set of flags each mnemonic raises.
    function automatic logic [20:0] exp_ctrl(input logic [31:0] ins);
        logic [20:0] rtype;
        logic [20:0] c;
        rtype = bit_of(B_WRD) | bit_of(B_RS) | bit_of(B_RT) | bit_of(B_RW) | bit_of(B_INC);
        c = '0;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: c = rtype | alu(2);
                6'h22: c = rtype | alu(6);
                6'h24: c = rtype | alu(0);
                6'h25: c = rtype | alu(1);
                6'h2A: c = rtype | alu(7);
                6'h08: c = bit_of(B_JR) | bit_of(B_RS) | bit_of(B_INC);
                default: c = '0;
            endcase
            6'h08: c = bit_of(B_SEX) | bit_of(B_IMM) | alu(2) | bit_of(B_RS) | bit_of(B_RW) | bit_of(B_INC);
            6'h0C: c = bit_of(B_IMM) | alu(0) | bit_of(B_RS) | bit_of(B_RW) | bit_of(B_INC);
            6'h0D: c = bit_of(B_IMM) | alu(1) | bit_of(B_RS) | bit_of(B_RW) | bit_of(B_INC);
            6'h0F: c = bit_of(B_LDIC) | bit_of(B_IMM) | bit_of(B_RW) | bit_of(B_INC);
            6'h23: c = bit_of(B_SEX) | bit_of(B_IMM) | alu(2) | bit_of(B_RS) | bit_of(B_MR) |
                       bit_of(B_LW) | bit_of(B_RW) | bit_of(B_INC);
            6'h2B: c = bit_of(B_SEX) | bit_of(B_IMM) | alu(2) | bit_of(B_RS) | bit_of(B_RT) |
                       bit_of(B_MW) | bit_of(B_INC);
            6'h04: c = bit_of(B_SEX) | alu(6) | bit_of(B_RS) | bit_of(B_RT) | bit_of(B_INC);
            6'h02: c = bit_of(B_J) | bit_of(B_INC);
            6'h03: c = bit_of(B_J) | bit_of(B_LINK) | bit_of(B_RW) | bit_of(B_INC);
            6'h30: c = bit_of(B_SC) | bit_of(B_INC);
            6'h31: c = bit_of(B_SI) | bit_of(B_INC);
            6'h32: c = bit_of(B_SP) | bit_of(B_INC);
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // Register read as seen by ID this cycle, including the same-cycle WB value.
    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic wen,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (idx == 0) return 32'h0;
        if (wen && wa == idx) return wd;
        return m_rf[idx];
    endfunction

    function automatic logic m_luh(input logic [31:0] ins, input logic v);
        logic [20:0] c;
        c = exp_ctrl(ins);
        if (!(v && m_valid && m_ctrl[B_LW] && m_dest != 0)) return 1'b0;
        return (c[B_RS] && ins[25:21] == m_dest) || (c[B_RT] && ins[20:16] == m_dest);
    endfunction

    // One clock: drive ID/WB/EX inputs, check stall_if, advance the model, check ID/EX after the edge.
    task automatic step(input logic [31:0] ins, input logic v, input logic wen, input logic [4:0] wa,
                        input logic [31:0] wd, input logic fl, input logic ho);
        logic        luh;
        logic [20:0] c;
        logic [4:0]  d;
        bus.id_instr = ins;
        bus.id_valid = v;
        bus.wb_wen   = wen;
        bus.wb_waddr = wa;
        bus.wb_wdata = wd;
        bus.ex_flush = fl;
        bus.ex_hold  = ho;
        #1;
        last_stall = bus.stall_if;
        luh = m_luh(ins, v);
        if (!rst) check("stall_if", 64'(last_stall), 64'(!fl && (ho || luh)));
        c = exp_ctrl(ins);
        d = c[B_LINK] ? 5'd31 : (c[B_WRD] ? ins[15:11] : ins[20:16]);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
            m_valid = 0; m_instr = 0; m_rs = 0; m_rt = 0; m_dest = 0; m_ctrl = 0;
        end else begin
            if (fl || (!ho && luh)) begin
                m_valid = 0;
                m_ctrl  = 0;
            end else if (!ho) begin
                m_valid = v;
                m_instr = ins;
                m_rs    = m_read(ins[25:21], wen, wa, wd);
                m_rt    = m_read(ins[20:16], wen, wa, wd);
                m_dest  = d;
                m_ctrl  = v ? c : '0;
            end
            if (wen && wa != 0) m_rf[wa] = wd;
        end
        @(posedge clk);
        #2;
        check("ex_valid", 64'(bus.ex_valid), 64'(m_valid));
        check("ex_ctrl", 64'(bus.ex_ctrl), 64'(m_ctrl));
        if (m_valid) begin
            check("ex_instr", 64'(bus.ex_instr), 64'(m_instr));
            check("ex_rs_data", 64'(bus.ex_rs_data), 64'(m_rs));
            check("ex_rt_data", 64'(bus.ex_rt_data), 64'(m_rt));
            check("ex_dest", 64'(bus.ex_dest), 64'(m_dest));
        end
    endtask

    function automatic int pick_reg();
        case ($urandom_range(0, 4))
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 7;
            default: return int'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        int rs, rt, rd;
        rs = pick_reg(); rt = pick_reg(); rd = pick_reg();
        case ($urandom_range(0, 17))
            0, 1:  return i_type(6'h23, rs, rt, int'($urandom_range(0, 255)));
            2:     return r_type(rs, rt, rd, 6'h20);
            3:     return r_type(rs, rt, rd, 6'h22);
            4:     return r_type(rs, rt, rd, 6'h24);
            5:     return r_type(rs, rt, rd, 6'h25);
            6:     return r_type(rs, rt, rd, 6'h2A);
            7:     return r_type(rs, 0, 0, 6'h08);
            8:     return i_type(6'h08, rs, rt, 5);
            9:     return i_type(6'h0C, rs, rt, 3);
            10:    return i_type(6'h0D, rs, rt, 9);
            11:    return i_type(6'h0F, 0, rt, 1);
            12:    return i_type(6'h2B, rs, rt, 4);
            13:    return i_type(6'h04, rs, rt, 2);
            14:    return {6'h02, 26'($urandom)};
            15:    return {6'h03, 26'($urandom)};
            16:    return {6'(6'h30 + 6'($urandom_range(0, 2))), 26'h0};
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] add_x;
    logic [31:0] cur_i;
    logic        cur_v;
    logic        fl;
    logic        ho;

    initial begin
        m_valid = 0; m_instr = 0; m_rs = 0; m_rt = 0; m_dest = 0; m_ctrl = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;

        // Reset held for two cycles.
        rst = 1'b1;
        step(32'h0, 0, 0, 0, 0, 0, 0);
        step(32'h0, 0, 1, 5, 32'h55, 0, 0);
        rst = 1'b0;
        check("rst_ex_valid", 64'(bus.ex_valid), 64'h0);
        check("rst_ex_instr", 64'(bus.ex_instr), 64'h0);
        check("rst_ex_ctrl", 64'(bus.ex_ctrl), 64'h0);
        check("rst_ex_dest", 64'(bus.ex_dest), 64'h0);
        check("rst_ex_data", 64'({bus.ex_rs_data, bus.ex_rt_data}), 64'h0);
        for (int i = 1; i < 32; i++) begin
            step(r_type(i, i, 1, 6'h20), 1, 0, 0, 0, 0, 0);
            check("rst_read", 64'({bus.ex_rs_data, bus.ex_rt_data}), 64'h0);
        end

        // Write-through bypass, and r0 stays zero.
        step(r_type(5, 0, 3, 6'h20), 1, 1, 5, 32'hDEADBEEF, 0, 0);
        check("bypass_rs", 64'(bus.ex_rs_data), 64'hDEADBEEF);
        step(r_type(0, 5, 3, 6'h20), 1, 1, 0, 32'h1234, 0, 0);
        check("r0_zero", 64'(bus.ex_rs_data), 64'h0);
        check("r5_kept", 64'(bus.ex_rt_data), 64'hDEADBEEF);

        // Load-use: one bubble, then the consumer enters EX.
        step(i_type(6'h23, 0, 7, 16), 1, 0, 0, 0, 0, 0);
        check("lw_ctrl", 64'(bus.ex_ctrl), 64'h64551);
        check("lw_dest", 64'(bus.ex_dest), 64'd7);
        add_x = r_type(7, 0, 3, 6'h20);
        step(add_x, 1, 0, 0, 0, 0, 0);
        check("luh_stall", 64'(last_stall), 64'h1);
        check("luh_bubble", 64'(bus.ex_valid), 64'h0);
        step(add_x, 1, 0, 0, 0, 0, 0);
        check("luh_release", 64'(last_stall), 64'h0);
        check("luh_enter", 64'({bus.ex_valid, bus.ex_instr}), 64'({1'b1, add_x}));
        step(i_type(6'h23, 0, 0, 16), 1, 0, 0, 0, 0, 0);
        step(r_type(0, 0, 3, 6'h20), 1, 0, 0, 0, 0, 0);
        check("lw_r0_nostall", 64'({last_stall, bus.ex_valid}), 64'b01);

        // Flush beats hold and load-use.
        step(i_type(6'h23, 0, 7, 16), 1, 0, 0, 0, 0, 0);
        step(add_x, 1, 0, 0, 0, 1, 1);
        check("flush_stall", 64'(last_stall), 64'h0);
        check("flush_bubble", 64'({bus.ex_valid, bus.ex_ctrl}), 64'h0);

        // Hold: ID/EX frozen for three cycles while a WB write still lands.
        add_x = r_type(1, 2, 3, 6'h20);
        step(add_x, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(r_type(4, 4, 4, 6'h22), 1, 1, 9, 32'h99, 0, 1);
            check("hold_stall", 64'(last_stall), 64'h1);
            check("hold_frozen", 64'({bus.ex_valid, bus.ex_instr}), 64'({1'b1, add_x}));
        end
        step(r_type(9, 0, 4, 6'h20), 1, 0, 0, 0, 0, 0);
        check("hold_wb_landed", 64'(bus.ex_rs_data), 64'h99);

        // Destination selection.
        step({6'h03, 26'h40}, 1, 0, 0, 0, 0, 0);
        check("dest_link", 64'(bus.ex_dest), 64'd31);
        step(r_type(1, 2, 12, 6'h25), 1, 0, 0, 0, 0, 0);
        check("dest_rd", 64'(bus.ex_dest), 64'd12);
        step(i_type(6'h08, 1, 4, 7), 1, 0, 0, 0, 0, 0);
        check("dest_rt", 64'(bus.ex_dest), 64'd4);

        // Randomized traffic; a stalled instruction is re-presented as IF would.
        cur_i = rand_instr();
        cur_v = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            fl = ($urandom_range(0, 11) == 0);
            ho = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 399) == 0);
            step(cur_i, cur_v, 1'($urandom_range(0, 1)), 5'(pick_reg()), $urandom, fl, ho);
            if (rst || !last_stall) begin
                cur_i = rand_instr();
                cur_v = ($urandom_range(0, 4) != 0);
            end
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
